// File: rtl/prng_sample_ctrl.sv
// Sample controller for the PRNG display: tick divider, button conditioning,
// an 8-deep sample history and a RUN/HOLD browser over that history.
module prng_sample_ctrl #(
  parameter logic [23:0] TICK_DIV = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] rnd_byte,
  input  logic       btn_hold,
  input  logic       btn_step,
  output logic       tick_out,
  output logic [7:0] disp_byte,
  output logic [2:0] hist_idx,
  output logic       hold_led,
  output logic       buf_full
);
  localparam int unsigned CW    = 24;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;
  localparam int unsigned FW    = 4;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [2:0]    hold_sync;
  logic [2:0]    step_sync;
  logic          hold_pulse;
  logic          step_pulse;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [FW-1:0] fill;
  logic [PW-1:0] newest_ptr;
  logic [PW-1:0] step_idx;
  logic [PW-1:0] step_ptr;

  // Sample-rate divider; ena low parks it at zero.
  assign tick = ena && (div_cnt == TICK_DIV - 24'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!ena || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 24'd1;
    end
  end

  // Two synchronizer flops plus one history flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_sync <= '0;
      step_sync <= '0;
    end else begin
      hold_sync <= {hold_sync[1:0], btn_hold};
      step_sync <= {step_sync[1:0], btn_step};
    end
  end

  assign hold_pulse = hold_sync[1] & ~hold_sync[2];
  assign step_pulse = step_sync[1] & ~step_sync[2];

  // History age after a step wraps once it reaches the oldest stored sample.
  assign newest_ptr = wr_ptr - 3'd1;
  assign step_idx   = ({1'b0, hist_idx} == fill - 4'd1) ? 3'd0 : hist_idx + 3'd1;
  assign step_ptr   = newest_ptr - step_idx;

  // The LFSRs only advance while samples are being captured.
  assign tick_out = tick && (state == RUN);
  assign hold_led = (state == HOLD);
  assign buf_full = (fill == FW'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wr_ptr    <= '0;
      fill      <= '0;
      hist_idx  <= '0;
      disp_byte <= '0;
      mem       <= '{default: '0};
    end else begin
      case (state)
        RUN: begin
          if (tick) begin
            mem[wr_ptr] <= rnd_byte;
            wr_ptr      <= wr_ptr + 3'd1;
            disp_byte   <= rnd_byte;
            if (fill != FW'(DEPTH)) begin
              fill <= fill + 4'd1;
            end
          end
          if (hold_pulse) begin
            state    <= HOLD;
            hist_idx <= '0;
          end
        end
        HOLD: begin
          if (hold_pulse) begin
            state     <= RUN;
            hist_idx  <= '0;
            disp_byte <= (fill == '0) ? '0 : mem[newest_ptr];
          end else if (step_pulse && (fill != '0)) begin
            hist_idx  <= step_idx;
            disp_byte <= mem[step_ptr];
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_sample_ctrl.sv
// Bench for prng_sample_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the sample history.
module tb_prng_sample_ctrl;
  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [7:0] rnd_byte;
  logic       btn_hold;
  logic       btn_step;
  logic       tick_out;
  logic [7:0] disp_byte;
  logic [2:0] hist_idx;
  logic       hold_led;
  logic       buf_full;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: newest sample at the front of the queue.
  byte unsigned hq[$];
  bit           m_hold;
  int           m_idx;
  int unsigned  m_cnt;
  bit           hb1, hb2, hb3, sb1, sb2, sb3;
  logic         s_tick;

  prng_sample_ctrl #(.TICK_DIV(24'd4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .rnd_byte  (rnd_byte),
    .btn_hold  (btn_hold),
    .btn_step  (btn_step),
    .tick_out  (tick_out),
    .disp_byte (disp_byte),
    .hist_idx  (hist_idx),
    .hold_led  (hold_led),
    .buf_full  (buf_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit exp_tick();
    return !m_hold && (ena === 1'b1) && (m_cnt == TD - 1);
  endfunction

  function automatic logic [7:0] exp_disp();
    if (hq.size() == 0) return 8'h00;
    return hq[m_hold ? m_idx : 0];
  endfunction

  task automatic model_clear();
    hq.delete();
    m_hold = 1'b0;
    m_idx  = 0;
    m_cnt  = 0;
    {hb1, hb2, hb3, sb1, sb2, sb3} = '0;
  endtask

  task automatic model_edge();
    bit t, hp, sp;
    t  = (ena === 1'b1) && (m_cnt == TD - 1);
    hp = hb2 && !hb3;
    sp = sb2 && !sb3;
    if (!m_hold) begin
      if (t) begin
        hq.push_front(rnd_byte);
        if (hq.size() > 8) void'(hq.pop_back());
      end
      if (hp) begin
        m_hold = 1'b1;
        m_idx  = 0;
      end
    end else if (hp) begin
      m_hold = 1'b0;
      m_idx  = 0;
    end else if (sp && hq.size() != 0) begin
      m_idx = (m_idx + 1) % hq.size();
    end
    m_cnt = ((ena !== 1'b1) || t) ? 0 : m_cnt + 1;
    hb3 = hb2; hb2 = hb1; hb1 = btn_hold;
    sb3 = sb2; sb2 = sb1; sb1 = btn_step;
  endtask

  // Compare outputs mid-cycle, advance the model, then step past the edge.
  task automatic cycle();
    @(negedge clk);
    s_tick = tick_out;
    check("tick_out", 32'(tick_out), 32'(exp_tick()));
    check("disp_byte", 32'(disp_byte), 32'(exp_disp()));
    check("hist_idx", 32'(hist_idx), 32'(m_hold ? m_idx : 0));
    check("hold_led", 32'(hold_led), 32'(m_hold));
    check("buf_full", 32'(buf_full), 32'(hq.size() == 8));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_tick", 32'(tick_out), 32'd0);
    check("rst_disp", 32'(disp_byte), 32'd0);
    check("rst_hist", 32'(hist_idx), 32'd0);
    check("rst_hold_led", 32'(hold_led), 32'd0);
    check("rst_buf_full", 32'(buf_full), 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic press(input bit is_step);
    if (is_step) btn_step = 1'b1; else btn_hold = 1'b1;
    repeat (4) cycle();
    if (is_step) btn_step = 1'b0; else btn_hold = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!s_tick && k < 20);
    check("wait_tick_timeout", 32'(s_tick), 32'd1);
  endtask

  initial begin
    int nt;
    int k;
    reset = 1'b1; ena = 1'b1; rnd_byte = 8'hA5; btn_hold = 1'b0; btn_step = 1'b0;
    do_reset();

    // Tick cadence and first displayed sample after reset release.
    for (int c = 1; c <= 12; c++) begin
      cycle();
      check("t031_tick_cycle", 32'(s_tick), 32'((c % 4) == 0));
      if (c >= 5) check("t031_disp", 32'(disp_byte), 32'hA5);
    end

    // Ten samples 01..0A; the first two get overwritten.
    do_reset();
    nt = 0;
    for (int i = 0; i < 100 && nt < 10; i++) begin
      rnd_byte = 8'(nt + 1);
      cycle();
      if (s_tick) begin
        nt++;
        if (nt == 7) check("t032_not_full", 32'(buf_full), 32'd0);
        if (nt == 8) check("t032_full", 32'(buf_full), 32'd1);
      end
    end
    check("t032_ten_ticks", 32'(nt), 32'd10);

    // Browse history in HOLD, then wrap back to newest.
    press(1'b0);
    check("t033_hold", 32'(hold_led), 32'd1);
    check("t033_disp0", 32'(disp_byte), 32'h0A);
    for (int n = 1; n <= 8; n++) begin
      press(1'b1);
      if (n <= 3) begin
        check("t033_hist", 32'(hist_idx), 32'(n));
        check("t033_disp", 32'(disp_byte), 32'(8'h0A - 8'(n)));
      end
    end
    check("t033_wrap_hist", 32'(hist_idx), 32'd0);
    check("t033_wrap_disp", 32'(disp_byte), 32'h0A);

    // Hold pulse lands on a tick: sample captured and shown in HOLD.
    press(1'b0);
    wait_tick();
    rnd_byte = 8'h5C;
    cycle();
    btn_hold = 1'b1;
    repeat (3) cycle();
    check("t034_hold", 32'(hold_led), 32'd1);
    check("t034_disp", 32'(disp_byte), 32'h5C);
    btn_hold = 1'b0;
    repeat (4) cycle();

    // ena dropout restarts the divider.
    press(1'b0);
    wait_tick();
    repeat (2) cycle();
    ena = 1'b0;
    repeat (3) begin
      cycle();
      check("t035_no_tick", 32'(s_tick), 32'd0);
    end
    ena = 1'b1;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!s_tick && k < 10);
    check("t035_tick_delay", 32'(k), 32'd4);

    // Reset in HOLD with five samples discards all history.
    do_reset();
    nt = 0;
    for (int i = 0; i < 60 && nt < 5; i++) begin
      rnd_byte = 8'($urandom_range(255, 1));
      cycle();
      if (s_tick) nt++;
    end
    press(1'b0);
    check("t036_hold", 32'(hold_led), 32'd1);
    do_reset();
    press(1'b0);
    press(1'b1);
    check("t036_disp", 32'(disp_byte), 32'h00);
    check("t036_hist", 32'(hist_idx), 32'd0);
    check("t036_hold_after", 32'(hold_led), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ena      = ($urandom_range(9) != 0);
      rnd_byte = 8'($urandom);
      if ($urandom_range(11) == 0) btn_hold = ~btn_hold;
      if ($urandom_range(5) == 0) btn_step = ~btn_step;
      if ($urandom_range(599) == 0) do_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
